// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg
// Shared definitions for the SoC bus router:
//   bus_state_e      - transaction FSM states
//   ERR_DATA_DEFAULT - read word returned when a transaction is aborted
//   MAX_SLAVES       - largest supported slot count
//   SLOT_W           - width of a binary slot index
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_ABORT   = 2'd3
  } bus_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h6666_6666;
  localparam int unsigned MAX_SLAVES       = 16;
  localparam int unsigned SLOT_W           = $clog2(MAX_SLAVES);

endpackage

// File: rtl/soc_addr_decode.sv
// soc_addr_decode
// Combinational address decoder. The select field is offset by BASE_SEL;
// offsets 0..N_SLAVES-2 map to slots 1..N_SLAVES-1, everything else to
// slot 0 (program memory), so exactly one chip select is always active.
// Ports:
//   i_sel_field  in   SEL_W     select field of the CPU address
//   o_cs         out  N_SLAVES  one-hot slot select
//   o_slot       out  SLOT_W    binary slot index
module soc_addr_decode
  import soc_bus_pkg::*;
#(
  parameter int unsigned N_SLAVES = 8,
  parameter int unsigned SEL_W    = 16,
  parameter logic [31:0] BASE_SEL = 32'h0000_0040
) (
  input  logic [SEL_W-1:0]    i_sel_field,
  output logic [N_SLAVES-1:0] o_cs,
  output logic [SLOT_W-1:0]   o_slot
);

  localparam logic [SEL_W-1:0] BASE_W = SEL_W'(BASE_SEL);
  localparam logic [SEL_W-1:0] LAST_D = SEL_W'(N_SLAVES - 2);

  logic [SEL_W-1:0] w_d;

  always_comb begin
    // Wrap-around subtraction: fields below BASE_SEL become large and fall to slot 0.
    w_d    = i_sel_field - BASE_W;
    o_slot = '0;
    if (w_d <= LAST_D) begin
      o_slot = SLOT_W'(w_d) + SLOT_W'(1);
    end
    o_cs = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (o_slot == SLOT_W'(i)) begin
        o_cs[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_bus_router.sv
// soc_bus_router
// FemtoRV32 bus router: decodes the CPU address onto N_SLAVES slots,
// latches the target slot per transaction and routes read data / busy
// back from the latched slot. A watchdog aborts transactions whose slave
// stays busy too long, returning ERR_DATA and setting a sticky err flag.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mem_addr            CPU byte address
//   mem_rstrb           CPU read strobe (single-cycle)
//   mem_wmask           CPU byte write mask (nonzero = write)
//   mem_rdata           read data to CPU
//   mem_rbusy/wbusy     read / write stall to CPU
//   s_cs                one-hot combinational decode of mem_addr
//   s_rstrb, s_wmask    strobes forwarded to the decoded slot
//   s_rdata, s_rbusy,
//   s_wbusy             per-slot read data and busy flags
//   err_clr, err        sticky timeout flag and its clear
//   err_addr            address of the most recent timed-out access
module soc_bus_router
  import soc_bus_pkg::*;
#(
  parameter int unsigned N_SLAVES = 8,
  parameter int unsigned SEL_HI   = 31,
  parameter int unsigned SEL_LO   = 16,
  parameter logic [31:0] BASE_SEL = 32'h0000_0040,
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             mem_addr,
  input  logic                    mem_rstrb,
  input  logic [3:0]              mem_wmask,
  output logic [31:0]             mem_rdata,
  output logic                    mem_rbusy,
  output logic                    mem_wbusy,
  output logic [N_SLAVES-1:0]     s_cs,
  output logic [N_SLAVES-1:0]     s_rstrb,
  output logic [4*N_SLAVES-1:0]   s_wmask,
  input  logic [32*N_SLAVES-1:0]  s_rdata,
  input  logic [N_SLAVES-1:0]     s_rbusy,
  input  logic [N_SLAVES-1:0]     s_wbusy,
  input  logic                    err_clr,
  output logic                    err,
  output logic [31:0]             err_addr
);

  localparam int unsigned SEL_W = SEL_HI - SEL_LO + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  bus_state_e        r_state;
  logic [SLOT_W-1:0] r_sel;
  logic [31:0]       r_addr;
  logic [WD_W-1:0]   r_wd;
  logic              r_err;
  logic [31:0]       r_err_addr;

  logic [SEL_W-1:0]    w_sel_field;
  logic [N_SLAVES-1:0] w_cs;
  logic [SLOT_W-1:0]   w_slot;
  logic [31:0]         w_rdata_sel;
  logic                w_rbusy_sel;
  logic                w_wbusy_sel;
  logic                w_wait_busy;

  assign w_sel_field = mem_addr[SEL_HI:SEL_LO];

  soc_addr_decode #(
    .N_SLAVES (N_SLAVES),
    .SEL_W    (SEL_W),
    .BASE_SEL (BASE_SEL)
  ) u_decode (
    .i_sel_field (w_sel_field),
    .o_cs        (w_cs),
    .o_slot      (w_slot)
  );

  // Return path always follows the latched slot, never the live address.
  always_comb begin
    w_rdata_sel = '0;
    w_rbusy_sel = 1'b0;
    w_wbusy_sel = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (r_sel == SLOT_W'(i)) begin
        w_rdata_sel = s_rdata[32*i +: 32];
        w_rbusy_sel = s_rbusy[i];
        w_wbusy_sel = s_wbusy[i];
      end
    end
  end

  always_comb begin
    s_cs    = w_cs;
    s_rstrb = mem_rstrb ? w_cs : '0;
    s_wmask = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (w_cs[i]) begin
        s_wmask[4*i +: 4] = mem_wmask;
      end
    end
  end

  always_comb begin
    mem_rbusy   = (r_state == ST_RD_WAIT) && w_rbusy_sel;
    mem_wbusy   = (r_state == ST_WR_WAIT) && w_wbusy_sel;
    w_wait_busy = mem_rbusy || mem_wbusy;
    mem_rdata   = (r_state == ST_ABORT) ? ERR_DATA : w_rdata_sel;
    err         = r_err;
    err_addr    = r_err_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wd       <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      // Clear first so the abort assignment below takes priority.
      if (err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (mem_wmask != '0) begin
            r_state <= ST_WR_WAIT;
            r_sel   <= w_slot;
            r_addr  <= mem_addr;
            r_wd    <= '0;
          end else if (mem_rstrb) begin
            r_state <= ST_RD_WAIT;
            r_sel   <= w_slot;
            r_addr  <= mem_addr;
            r_wd    <= '0;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          if (w_wait_busy) begin
            if (r_wd == WD_W'(TIMEOUT)) begin
              r_state <= ST_ABORT;
            end else begin
              r_wd <= r_wd + WD_W'(1);
            end
          end else if (mem_wmask != '0) begin
            r_state <= ST_WR_WAIT;
            r_sel   <= w_slot;
            r_addr  <= mem_addr;
            r_wd    <= '0;
          end else if (mem_rstrb) begin
            r_state <= ST_RD_WAIT;
            r_sel   <= w_slot;
            r_addr  <= mem_addr;
            r_wd    <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          r_err      <= 1'b1;
          r_err_addr <= r_addr;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_router.sv
module tb_soc_bus_router;

  localparam int unsigned N = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       mem_addr;
  logic              mem_rstrb;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_rdata;
  logic              mem_rbusy;
  logic              mem_wbusy;
  logic [N-1:0]      s_cs;
  logic [N-1:0]      s_rstrb;
  logic [4*N-1:0]    s_wmask;
  logic [32*N-1:0]   s_rdata;
  logic [N-1:0]      s_rbusy;
  logic [N-1:0]      s_wbusy;
  logic              err_clr;
  logic              err;
  logic [31:0]       err_addr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  soc_bus_router #(
    .N_SLAVES (N),
    .TIMEOUT  (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_rbusy (mem_rbusy),
    .mem_wbusy (mem_wbusy),
    .s_cs      (s_cs),
    .s_rstrb   (s_rstrb),
    .s_wmask   (s_wmask),
    .s_rdata   (s_rdata),
    .s_rbusy   (s_rbusy),
    .s_wbusy   (s_wbusy),
    .err_clr   (err_clr),
    .err       (err),
    .err_addr  (err_addr)
  );

  function automatic logic [31:0] slot_data(input int unsigned i);
    return (i == 3) ? 32'h1234_5678 : (32'hA5A5_0000 + i);
  endfunction

  function automatic int unsigned model_slot(input logic [31:0] a);
    logic [15:0] d;
    d = a[31:16] - 16'h0040;
    return (d <= 16'd6) ? (int'(d) + 1) : 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int unsigned s);
    logic [N-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_rbusy !== 1'b0) $display("FAIL reset_rbusy got %b want 0", mem_rbusy); else n_pass++;
    n_checks++; if (mem_wbusy !== 1'b0) $display("FAIL reset_wbusy got %b want 0", mem_wbusy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_checks++; if (err_addr !== 32'h0) $display("FAIL reset_err_addr got %h want 0", err_addr); else n_pass++;
    n_checks++; if (mem_rdata !== slot_data(0)) $display("FAIL reset_rdata got %h want %h", mem_rdata, slot_data(0)); else n_pass++;
    n_checks++; if (s_cs !== 8'h01) $display("FAIL reset_cs got %h want 01", s_cs); else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] addrs [6];
    addrs = '{32'h0000_0000, 32'h003F_FFFC, 32'h0040_0000, 32'h0046_0010, 32'h0047_0000, 32'hFFFF_0000};
    for (int i = 0; i < 6; i++) begin
      tick();
      mem_addr = addrs[i];
      @(negedge clk);
      n_checks++;
      if (s_cs !== onehot(model_slot(addrs[i])))
        $display("FAIL decode_cs addr %h got %h want %h", addrs[i], s_cs, onehot(model_slot(addrs[i])));
      else n_pass++;
      n_checks++;
      if (s_rstrb !== '0 || s_wmask !== '0)
        $display("FAIL decode_idle_strobes addr %h got rstrb %h wmask %h want 0", addrs[i], s_rstrb, s_wmask);
      else n_pass++;
    end
  endtask

  task automatic test_read(input logic [31:0] addr, input int unsigned busy_n,
                           input bit chg, input logic [31:0] alt);
    int unsigned slot;
    int unsigned seen;
    bit          done;
    logic [31:0] exp;
    slot = model_slot(addr);
    seen = 0;
    done = 1'b0;
    tick();
    mem_addr  = addr;
    mem_rstrb = 1'b1;
    s_rbusy   = '0;
    exp_q.push_back(slot_data(slot));
    @(negedge clk);
    n_checks++; if (s_cs !== onehot(slot)) $display("FAIL read_cs addr %h got %h want %h", addr, s_cs, onehot(slot)); else n_pass++;
    n_checks++; if (s_rstrb !== onehot(slot)) $display("FAIL read_rstrb addr %h got %h want %h", addr, s_rstrb, onehot(slot)); else n_pass++;
    n_checks++; if (mem_rbusy !== 1'b0) $display("FAIL read_busy_T addr %h got %b want 0", addr, mem_rbusy); else n_pass++;
    for (int unsigned k = 1; k <= 40 && !done; k++) begin
      tick();
      mem_rstrb = 1'b0;
      if (chg) mem_addr = alt;
      s_rbusy = (k <= busy_n) ? onehot(slot) : '0;
      @(negedge clk);
      if (chg && k == 1) begin
        n_checks++;
        if (s_cs !== onehot(model_slot(alt))) $display("FAIL read_cs_follow got %h want %h", s_cs, onehot(model_slot(alt)));
        else n_pass++;
      end
      if (mem_rbusy === 1'b1) seen++;
      else begin
        done = 1'b1;
        exp  = exp_q.pop_front();
        n_checks++; if (mem_rdata !== exp) $display("FAIL read_data addr %h got %h want %h", addr, mem_rdata, exp); else n_pass++;
      end
    end
    n_checks++; if (done !== 1'b1) $display("FAIL read_timeout addr %h got no completion want completion", addr); else n_pass++;
    n_checks++; if (seen !== busy_n) $display("FAIL read_busy_cycles addr %h got %0d want %0d", addr, seen, busy_n); else n_pass++;
    s_rbusy = '0;
  endtask

  task automatic test_write();
    int unsigned seen;
    bit          done;
    seen = 0;
    done = 1'b0;
    tick();
    mem_addr  = 32'h0045_0010;
    mem_wmask = 4'b0011;
    s_wbusy   = '0;
    @(negedge clk);
    n_checks++; if (s_wmask !== 32'h0300_0000) $display("FAIL write_wmask got %h want 03000000", s_wmask); else n_pass++;
    n_checks++; if (s_cs !== 8'h40) $display("FAIL write_cs got %h want 40", s_cs); else n_pass++;
    n_checks++; if (mem_wbusy !== 1'b0) $display("FAIL write_busy_T got %b want 0", mem_wbusy); else n_pass++;
    for (int unsigned k = 1; k <= 40 && !done; k++) begin
      tick();
      mem_wmask = 4'b0000;
      s_wbusy   = (k <= 3) ? onehot(6) : '0;
      @(negedge clk);
      if (mem_wbusy === 1'b1) seen++;
      else done = 1'b1;
    end
    n_checks++; if (done !== 1'b1) $display("FAIL write_timeout got no completion want completion"); else n_pass++;
    n_checks++; if (seen !== 3) $display("FAIL write_busy_cycles got %0d want 3", seen); else n_pass++;
    n_checks++; if (mem_rbusy !== 1'b0) $display("FAIL write_rbusy got %b want 0", mem_rbusy); else n_pass++;
    s_wbusy = '0;
  endtask

  task automatic test_timeout();
    logic [31:0] addr;
    int unsigned seen;
    bit          done;
    addr = 32'h0045_0020;
    seen = 0;
    done = 1'b0;
    tick();
    mem_addr  = addr;
    mem_rstrb = 1'b1;
    s_rbusy   = onehot(6);
    err_clr   = 1'b1;
    for (int unsigned k = 1; k <= 40 && !done; k++) begin
      tick();
      mem_rstrb = 1'b0;
      @(negedge clk);
      if (mem_rbusy === 1'b1) seen++;
      else begin
        done = 1'b1;
        n_checks++; if (mem_rdata !== 32'h6666_6666) $display("FAIL abort_rdata got %h want 66666666", mem_rdata); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL abort_err_early got %b want 0", err); else n_pass++;
      end
    end
    n_checks++; if (seen !== 8) $display("FAIL abort_busy_cycles got %0d want 8", seen); else n_pass++;
    tick();
    s_rbusy = '0;
    @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL abort_err_set got %b want 1", err); else n_pass++;
    n_checks++; if (err_addr !== addr) $display("FAIL abort_err_addr got %h want %h", err_addr, addr); else n_pass++;
    n_checks++; if (mem_rbusy !== 1'b0) $display("FAIL abort_late_rbusy got %b want 0", mem_rbusy); else n_pass++;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== 1'b0) $display("FAIL abort_err_clr got %b want 0", err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    tick();
    mem_addr  = 32'h0041_0000;
    mem_rstrb = 1'b1;
    s_rbusy   = '0;
    exp_q.push_back(slot_data(2));
    tick();
    mem_rstrb = 1'b0;
    s_rbusy   = onehot(2);
    @(negedge clk);
    n_checks++; if (mem_rbusy !== 1'b1) $display("FAIL b2b_busy1 got %b want 1", mem_rbusy); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (mem_rbusy !== 1'b1) $display("FAIL b2b_busy2 got %b want 1", mem_rbusy); else n_pass++;
    tick();
    s_rbusy   = '0;
    mem_addr  = 32'h0043_0000;
    mem_rstrb = 1'b1;
    exp_q.push_back(slot_data(4));
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++; if (mem_rbusy !== 1'b0) $display("FAIL b2b_first_done got %b want 0", mem_rbusy); else n_pass++;
    n_checks++; if (mem_rdata !== exp) $display("FAIL b2b_first_data got %h want %h", mem_rdata, exp); else n_pass++;
    n_checks++; if (s_rstrb !== onehot(4)) $display("FAIL b2b_second_rstrb got %h want %h", s_rstrb, onehot(4)); else n_pass++;
    tick();
    mem_rstrb = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++; if (mem_rbusy !== 1'b0) $display("FAIL b2b_second_done got %b want 0", mem_rbusy); else n_pass++;
    n_checks++; if (mem_rdata !== exp) $display("FAIL b2b_second_data got %h want %h", mem_rdata, exp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit done;
    done = 1'b0;
    tick();
    mem_addr  = 32'h0044_0008;
    mem_rstrb = 1'b1;
    s_rbusy   = onehot(5);
    for (int unsigned k = 1; k <= 40 && !done; k++) begin
      tick();
      mem_rstrb = 1'b0;
      @(negedge clk);
      if (mem_rbusy !== 1'b1) done = 1'b1;
    end
    tick();
    @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL rstmid_err_pre got %b want 1", err); else n_pass++;
    tick();
    mem_rstrb = 1'b1;
    tick();
    mem_rstrb = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_rbusy !== 1'b1) $display("FAIL rstmid_busy_pre got %b want 1", mem_rbusy); else n_pass++;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_rbusy !== 1'b0) $display("FAIL rstmid_rbusy got %b want 0", mem_rbusy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rstmid_err got %b want 0", err); else n_pass++;
    n_checks++; if (err_addr !== 32'h0) $display("FAIL rstmid_err_addr got %h want 0", err_addr); else n_pass++;
    s_rbusy = '0;
  endtask

  initial begin
    reset     = 1'b1;
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wmask = '0;
    s_rbusy   = '0;
    s_wbusy   = '0;
    err_clr   = 1'b0;
    for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = slot_data(i);

    test_reset();
    test_decode();
    test_read(32'h0042_0004, 0, 1'b0, 32'h0);
    test_read(32'h0000_0100, 5, 1'b1, 32'h0040_0000);
    test_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_bus_router.md
# soc_bus_router

- Parametrised replacement for the fixed chip-select decoder and read-data mux in the SoC top.
- Decodes FemtoRV32 bus addresses onto N_SLAVES slots and latches the target slot for each transaction.
- Routes read data and busy back from the latched slot, so a multi-cycle slave (SPI flash/RAM) cannot be mis-muxed.
- A timeout watchdog ends hung transactions with an error word and a sticky error flag.

## Interface
Parameters:
- N_SLAVES, 8, slot count (2..16); slot 0 is the default (program memory).
- SEL_HI, 31, MSB of the address select field.
- SEL_LO, 16, LSB of the address select field.
- BASE_SEL, 16'h0040, select value of slot 1; slot i (i>=1) matches BASE_SEL+i-1.
- TIMEOUT, 1023, maximum busy cycles before abort (>=1).
- ERR_DATA, 32'h66666666, read data returned on timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- mem_addr  in  32  CPU byte address.
- mem_rstrb  in  1  CPU read strobe, single-cycle pulse.
- mem_wmask  in  4  CPU byte write mask; nonzero marks a single-cycle write.
- mem_rdata  out  32  read data to CPU.
- mem_rbusy  out  1  read stall to CPU.
- mem_wbusy  out  1  write stall to CPU.
- s_cs  out  N_SLAVES  one-hot combinational decode of mem_addr, for cs/rd/wr peripherals.
- s_rstrb  out  N_SLAVES  read strobe to the decoded slot.
- s_wmask  out  4*N_SLAVES  write mask to the decoded slot; slot i uses bits [4i+3:4i].
- s_rdata  in  32*N_SLAVES  slave read data.
- s_rbusy  in  N_SLAVES  slave read busy.
- s_wbusy  in  N_SLAVES  slave write busy.
- err_clr  in  1  clears err.
- err  out  1  sticky timeout flag.
- err_addr  out  32  address of the most recent timed-out access.

## Operation
- Decode:
  - d = mem_addr[SEL_HI:SEL_LO] - BASE_SEL, computed at the select-field width.
  - If 0 <= d <= N_SLAVES-2, the slot is d+1; otherwise slot 0.
  - s_cs is always exactly one-hot.
- Strobe routing:
  - s_rstrb[i] = mem_rstrb & s_cs[i].
  - s_wmask slice i = mem_wmask when s_cs[i], else 0.
  - Both are combinational, with no added latency.
- FSM states:
  - IDLE: on mem_wmask!=0 latch sel_q = decoded slot and addr_q, go to WR_WAIT. Otherwise, on mem_rstrb latch the same and go to RD_WAIT.
  - RD_WAIT: mem_rbusy = s_rbusy[sel_q]. When s_rbusy[sel_q]=0, that cycle completes the read and the FSM returns to IDLE. If a new mem_rstrb arrives in that same completion cycle, it is latched and the FSM stays in RD_WAIT (back-to-back reads).
  - WR_WAIT: mem_wbusy = s_wbusy[sel_q]. It exits to IDLE, or re-latches on a new access, with the same rules as RD_WAIT.
  - ABORT: a single cycle. mem_rbusy=mem_wbusy=0, mem_rdata=ERR_DATA, err<=1, err_addr<=addr_q. Then IDLE.
- Watchdog:
  - wd_cnt clears on every latch and increments each cycle the selected busy is high in RD_WAIT or WR_WAIT.
  - When wd_cnt==TIMEOUT with busy still high, the next state is ABORT.
  - A later completion from the aborted slave is ignored.
- mem_rdata = s_rdata[sel_q] in every state except ABORT.
- Simultaneous rstrb and nonzero wmask: the write wins and the read strobe is still forwarded combinationally. The CPU never issues both.
- Simultaneous err_clr and abort: the set wins.

## Timing
- Reset values:
  - FSM state IDLE, sel_q=0, addr_q=0, wd_cnt=0.
  - err=0, err_addr=0, mem_rbusy=0, mem_wbusy=0.
  - mem_rdata = s_rdata[0].
- A reset asserted mid-transaction returns the FSM to IDLE on the next edge; the outstanding transaction is dropped.
- Zero-wait slave: rstrb in cycle T, data valid and mem_rbusy=0 in T+1.
- Busy slave: mem_rbusy follows s_rbusy[sel_q] combinationally from T+1.
- Timeout:
  - An abort occurs when the slave is busy for TIMEOUT+1 consecutive wait cycles.
  - ERR_DATA is presented in the following cycle.
  - err is visible in the cycle after ABORT.
- Changes on mem_addr during RD_WAIT or WR_WAIT do not affect routing; only s_cs follows mem_addr.

## Structure
- Package soc_bus_pkg holds:
  - FSM state encodings (IDLE, RD_WAIT, WR_WAIT, ABORT).
  - ERR_DATA default.
  - A clog2-based slot-index width constant.
- Sub-module soc_addr_decode (combinational): mem_addr -> one-hot s_cs plus binary slot index.
- The FSM, watchdog and muxes live in soc_bus_router.

## Test plan
- Default N_SLAVES=8. Read 0x00420004, slot 3 zero-wait with s_rdata=0x12345678 -> s_cs=8'h08, s_rstrb[3] pulses, mem_rdata=0x12345678 in T+1, mem_rbusy never high.
- Read 0x00000100, slot 0 busy 5 cycles. Mem_addr is changed to 0x00400000 during the wait -> mem_rbusy high for 5 cycles, data still routed from slot 0.
- Write wmask=4'b0011 to 0x00450010 with s_wbusy[6] high 3 cycles -> s_wmask slice 6 = 4'b0011, all other slices 0, mem_wbusy high 3 cycles.
- TIMEOUT=7, slot 6 rbusy stuck at 1 -> mem_rbusy drops after 8 wait cycles, mem_rdata=0x66666666, err=1, err_addr=read address. Err_clr then clears err.
- Back-to-back reads with a second rstrb in the completion cycle of the first -> both complete with the correct data. Reset pulsed mid-read -> mem_rbusy=0 and err=0 in the next cycle.
